// File: rtl/snapshot_uploader_if.sv
// Upload/memory handshake bundle for snapshot_uploader.
// master: the uploader (drives the host byte stream and the RAM read port).
// slave : the host + RAM side (drives start/index/rd and returns mem_data).
interface snapshot_uploader_if #(
   parameter int ADDR_W = 14
);
   logic              up_start;
   logic [7:0]        up_index;
   logic              up_rd;
   logic [7:0]        up_data;
   logic [ADDR_W-1:0] up_addr;
   logic              up_valid;
   logic              up_busy;
   logic              up_done;
   logic              up_err;
   logic [1:0]        mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_data;

   modport master (
      input  up_start, up_index, up_rd, mem_data,
      output up_data, up_addr, up_valid, up_busy, up_done, up_err,
             mem_sel, mem_addr, mem_rd
   );

   modport slave (
      output up_start, up_index, up_rd, mem_data,
      input  up_data, up_addr, up_valid, up_busy, up_done, up_err,
             mem_sel, mem_addr, mem_rd
   );
endinterface

// File: rtl/snapshot_uploader.sv
// snapshot_uploader: streams one on-chip RAM region (char, colour or work RAM)
// byte-by-byte to the HPS host -- the reverse of the ROM download path.
// Each byte costs FETCH (mem_rd) + RD_LAT WAIT cycles + PRESENT (until up_rd).
// Optional feature macro: UPLOAD_CSUM_EN -- appends one checksum byte so the
// mod-256 sum of every uploaded byte is zero.
module snapshot_uploader #(
   parameter int ADDR_W     = 14,
   parameter int CHRAM_LEN  = 2048,
   parameter int COLRAM_LEN = 2048,
   parameter int WKRAM_LEN  = 16384,
   parameter int RD_LAT     = 1
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   snapshot_uploader_if.master  bus
);

   localparam int LW = ADDR_W + 1;
   // WAIT cycles counted down to zero; capture happens on the zero cycle
   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] offset_r;
   logic [LW-1:0]     len_r;
   logic [1:0]        wait_cnt_r;

   logic [7:0]        up_data_r;
   logic [ADDR_W-1:0] up_addr_r;
   logic              up_valid_r;
   logic              up_busy_r;
   logic              up_done_r;
   logic              up_err_r;
   logic [1:0]        mem_sel_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_rd_r;

   logic              idx_ok_s;
   logic [LW-1:0]     len_sel_s;
   logic [1:0]        sel_code_s;
   logic              last_s;

`ifdef UPLOAD_CSUM_EN
   logic [7:0]        sum_r;
   logic              csum_phase_r;

   // Byte that brings the running mod-256 sum back to zero.
   function automatic logic [7:0] csum_byte(input logic [7:0] sum);
      csum_byte = 8'd0 - sum;
   endfunction
`endif

   assign bus.up_data  = up_data_r;
   assign bus.up_addr  = up_addr_r;
   assign bus.up_valid = up_valid_r;
   assign bus.up_busy  = up_busy_r;
   assign bus.up_done  = up_done_r;
   assign bus.up_err   = up_err_r;
   assign bus.mem_sel  = mem_sel_r;
   assign bus.mem_addr = mem_addr_r;
   assign bus.mem_rd   = mem_rd_r;

   // Decode the requested region into a length and a RAM select code.
   always_comb begin
      idx_ok_s   = 1'b0;
      len_sel_s  = {LW{1'b0}};
      sel_code_s = 2'b00;
      case (bus.up_index)
         8'd0: begin
            idx_ok_s   = 1'b1;
            len_sel_s  = LW'(CHRAM_LEN);
            sel_code_s = 2'b01;
         end
         8'd1: begin
            idx_ok_s   = 1'b1;
            len_sel_s  = LW'(COLRAM_LEN);
            sel_code_s = 2'b10;
         end
         8'd2: begin
            idx_ok_s   = 1'b1;
            len_sel_s  = LW'(WKRAM_LEN);
            sel_code_s = 2'b11;
         end
         default: begin
            idx_ok_s   = 1'b0;
            len_sel_s  = {LW{1'b0}};
            sel_code_s = 2'b00;
         end
      endcase
   end

   // Last data byte of the region: offset == length-1 (offset never wraps).
   always_comb begin
      if ({1'b0, offset_r} == (len_r - LW'(1))) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end

   // Transfer FSM with all outputs registered.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         offset_r   <= {ADDR_W{1'b0}};
         len_r      <= {LW{1'b0}};
         wait_cnt_r <= 2'd0;
         up_data_r  <= 8'd0;
         up_addr_r  <= {ADDR_W{1'b0}};
         up_valid_r <= 1'b0;
         up_busy_r  <= 1'b0;
         up_done_r  <= 1'b0;
         up_err_r   <= 1'b0;
         mem_sel_r  <= 2'b00;
         mem_addr_r <= {ADDR_W{1'b0}};
         mem_rd_r   <= 1'b0;
`ifdef UPLOAD_CSUM_EN
         sum_r        <= 8'd0;
         csum_phase_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               up_valid_r <= 1'b0;
               if (bus.up_start && idx_ok_s) begin
                  len_r      <= len_sel_s;
                  mem_sel_r  <= sel_code_s;
                  up_err_r   <= 1'b0;
                  up_done_r  <= 1'b0;
                  up_busy_r  <= 1'b1;
                  offset_r   <= {ADDR_W{1'b0}};
                  mem_addr_r <= {ADDR_W{1'b0}};
                  mem_rd_r   <= 1'b1;
`ifdef UPLOAD_CSUM_EN
                  sum_r        <= 8'd0;
                  csum_phase_r <= 1'b0;
`endif
                  state_r    <= ST_FETCH;
               end else if (bus.up_start) begin
                  // Invalid region: report and finish without touching RAM.
                  up_err_r   <= 1'b1;
                  up_done_r  <= 1'b1;
                  up_busy_r  <= 1'b0;
                  mem_sel_r  <= 2'b00;
                  mem_rd_r   <= 1'b0;
               end else begin
                  up_done_r  <= 1'b0;
                  up_busy_r  <= 1'b0;
                  mem_sel_r  <= 2'b00;
                  mem_rd_r   <= 1'b0;
               end
            end

            ST_FETCH: begin
               mem_rd_r   <= 1'b0;
               wait_cnt_r <= WAIT_INIT;
               state_r    <= ST_WAIT;
            end

            ST_WAIT: begin
               if (wait_cnt_r == 2'd0) begin
`ifdef UPLOAD_CSUM_EN
                  if (csum_phase_r) begin
                     // Checksum byte sits one past the region; for a region
                     // of exactly 2^ADDR_W bytes this offset wraps to 0.
                     up_data_r <= csum_byte(sum_r);
                     up_addr_r <= len_r[ADDR_W-1:0];
                  end else begin
                     up_data_r <= bus.mem_data;
                     up_addr_r <= offset_r;
                  end
`else
                  up_data_r  <= bus.mem_data;
                  up_addr_r  <= offset_r;
`endif
                  up_valid_r <= 1'b1;
                  state_r    <= ST_PRESENT;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 2'd1;
               end
            end

            ST_PRESENT: begin
               if (bus.up_rd) begin
                  up_valid_r <= 1'b0;
`ifdef UPLOAD_CSUM_EN
                  if (csum_phase_r) begin
                     up_done_r <= 1'b1;
                     state_r   <= ST_FINISH;
                  end else begin
                     sum_r <= sum_r + up_data_r;
                     if (last_s) begin
                        // Run the checksum byte through FETCH/WAIT without a read.
                        csum_phase_r <= 1'b1;
                        state_r      <= ST_FETCH;
                     end else begin
                        offset_r   <= offset_r + ADDR_W'(1);
                        mem_addr_r <= offset_r + ADDR_W'(1);
                        mem_rd_r   <= 1'b1;
                        state_r    <= ST_FETCH;
                     end
                  end
`else
                  if (last_s) begin
                     up_done_r <= 1'b1;
                     state_r   <= ST_FINISH;
                  end else begin
                     offset_r   <= offset_r + ADDR_W'(1);
                     mem_addr_r <= offset_r + ADDR_W'(1);
                     mem_rd_r   <= 1'b1;
                     state_r    <= ST_FETCH;
                  end
`endif
               end else begin
                  up_valid_r <= 1'b1;
               end
            end

            ST_FINISH: begin
               up_done_r <= 1'b0;
               up_busy_r <= 1'b0;
               mem_sel_r <= 2'b00;
               state_r   <= ST_IDLE;
            end

            default: begin
               up_valid_r <= 1'b0;
               up_busy_r  <= 1'b0;
               up_done_r  <= 1'b0;
               mem_sel_r  <= 2'b00;
               mem_rd_r   <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snapshot_uploader.sv
// Directed self-checking bench for snapshot_uploader: reset, full chram
// upload, wkram backpressure, invalid index, start-while-busy, mid-transfer
// reset and (with UPLOAD_CSUM_EN) the appended checksum byte.
module tb_snapshot_uploader;

   localparam int ADDR_W     = 14;
   localparam int CHRAM_LEN  = 2048;
   localparam int COLRAM_LEN = 2048;
   localparam int WKRAM_LEN  = 16384;
`ifdef UPLOAD_CSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;

   snapshot_uploader_if #(.ADDR_W(ADDR_W)) bus ();

   snapshot_uploader #(
      .ADDR_W(ADDR_W), .CHRAM_LEN(CHRAM_LEN), .COLRAM_LEN(COLRAM_LEN),
      .WKRAM_LEN(WKRAM_LEN), .RD_LAT(1)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   initial forever #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_pass   = 0;

   int         mode = 0;
   logic [7:0] fill = 8'h00;
   logic [1:0] exp_sel = 2'b00;

   int rd_cnt = 0, done_cnt = 0, busy_cnt = 0, sel_err = 0;

   int n_got, acc_first, acc_last, addr_err, data_err, stall_err, stall_cyc, timeout;
   logic [ADDR_W-1:0] last_addr;
   logic [7:0]        last_data;

   // Contents every RAM returns for a given address in the current mode.
   function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] a);
      if (mode == 0)      exp_byte = a[7:0];
      else if (mode == 1) exp_byte = fill;
      else                exp_byte = (a == '0) ? 8'h06 : 8'h00;
   endfunction

   function automatic logic [63:0] outs_vec();
      outs_vec = {21'd0, bus.up_data, bus.up_addr, bus.up_valid, bus.up_busy,
                  bus.up_done, bus.up_err, bus.mem_sel, bus.mem_addr, bus.mem_rd};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Synchronous RAM model, one cycle read latency.
   always @(posedge clk_sys) begin
      if (bus.mem_rd) bus.mem_data <= exp_byte(bus.mem_addr);
   end

   // Event counters sampled at the active edge (pre-update values).
   always @(posedge clk_sys) begin
      if (bus.mem_rd)  rd_cnt   = rd_cnt + 1;
      if (bus.up_done) done_cnt = done_cnt + 1;
      if (bus.up_busy) busy_cnt = busy_cnt + 1;
      if (bus.up_busy && bus.mem_sel != exp_sel) sel_err = sel_err + 1;
   end

   // Host side: accept bytes, optionally stall, poke a start, or reset.
   task automatic collect(input int n_data, input int stall_at, input int bump_at, input int rst_at);
      int  stall_left;
      bit  fin;
      bit  bump_pending;
      logic [7:0]        snap_d;
      logic [ADDR_W-1:0] snap_a;
      n_got = 0; addr_err = 0; data_err = 0; stall_err = 0; stall_cyc = 0;
      acc_first = 0; acc_last = 0; timeout = 0;
      stall_left = 5; fin = 1'b0; bump_pending = 1'b1;
      snap_d = 8'h00; snap_a = '0;
      for (int c = 0; c < 60000 && !fin; c++) begin
         @(negedge clk_sys);
         bus.up_start = 1'b0;
         if (bus.up_done) begin
            fin = 1'b1;
         end else if (bus.up_valid && int'(bus.up_addr) == rst_at) begin
            reset = 1'b1;
            fin   = 1'b1;
         end else if (bus.up_valid) begin
            if (int'(bus.up_addr) == bump_at && bump_pending) begin
               bus.up_start = 1'b1;
               bus.up_index = 8'd2;
               bump_pending = 1'b0;
            end
            if (int'(bus.up_addr) == stall_at && stall_left > 0) begin
               if (stall_left == 5) begin
                  snap_d = bus.up_data;
                  snap_a = bus.up_addr;
               end else if (bus.up_data !== snap_d || bus.up_addr !== snap_a) begin
                  stall_err++;
               end
               stall_cyc++;
               stall_left--;
               bus.up_rd = 1'b0;
            end else begin
               bus.up_rd = 1'b1;
            end
            if (bus.up_rd) begin
               if (n_got < n_data) begin
                  if (int'(bus.up_addr) != n_got) addr_err++;
                  if (bus.up_data !== exp_byte(bus.up_addr)) data_err++;
                  if (n_got == 0) acc_first = c;
                  acc_last = c;
               end else begin
                  last_addr = bus.up_addr;
                  last_data = bus.up_data;
               end
               n_got++;
            end
         end else begin
            bus.up_rd = 1'b1;
         end
      end
      if (!fin) timeout = 1;
   endtask

   int rd0, d0, s0, b0;

   initial begin
      bus.up_start = 1'b0;
      bus.up_index = 8'd0;
      bus.up_rd    = 1'b0;
      last_addr    = '0;
      last_data    = 8'h00;

      // ---- reset values ----
      repeat (3) @(negedge clk_sys);
      check("rst_outs", outs_vec(), 64'd0);
      reset = 1'b0;
      rd0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt;
      repeat (10) @(negedge clk_sys);
      check("idle_outs", outs_vec(), 64'd0);
      check("idle_events", rd_cnt - rd0 + done_cnt - d0 + busy_cnt - b0, 0);

      // ---- full chram upload ----
      mode = 0; exp_sel = 2'b01;
      rd0 = rd_cnt; d0 = done_cnt; s0 = sel_err;
      bus.up_index = 8'd0; bus.up_start = 1'b1; bus.up_rd = 1'b1;
      collect(CHRAM_LEN, -1, -1, -1);
      check("ch_timeout", timeout, 0);
      check("ch_nbytes", n_got, CHRAM_LEN + CS);
      check("ch_addr_err", addr_err, 0);
      check("ch_data_err", data_err, 0);
      check("ch_rd_pulses", rd_cnt - rd0, CHRAM_LEN);
      check("ch_spacing", acc_last - acc_first, 3 * (CHRAM_LEN - 1));
      @(negedge clk_sys);
      check("ch_done_cnt", done_cnt - d0, 1);
      check("ch_end_idle", {bus.up_busy, bus.mem_sel, bus.up_valid}, 0);
      check("ch_sel", sel_err - s0, 0);

      // ---- wkram with backpressure on byte 0x123 ----
      exp_sel = 2'b11;
      rd0 = rd_cnt; d0 = done_cnt; s0 = sel_err;
      bus.up_index = 8'd2; bus.up_start = 1'b1;
      collect(WKRAM_LEN, 'h123, -1, -1);
      check("wk_timeout", timeout, 0);
      check("wk_nbytes", n_got, WKRAM_LEN + CS);
      check("wk_addr_err", addr_err, 0);
      check("wk_data_err", data_err, 0);
      check("wk_stall_cyc", stall_cyc, 5);
      check("wk_stall_stable", stall_err, 0);
      check("wk_rd_pulses", rd_cnt - rd0, WKRAM_LEN);
      check("wk_spacing", acc_last - acc_first, 3 * (WKRAM_LEN - 1) + 5);
      @(negedge clk_sys);
      check("wk_done_cnt", done_cnt - d0, 1);
      check("wk_sel", sel_err - s0, 0);

      // ---- invalid index ----
      rd0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt;
      bus.up_index = 8'd5; bus.up_start = 1'b1;
      @(negedge clk_sys);
      bus.up_start = 1'b0;
      check("inv_err_done", {bus.up_err, bus.up_done, bus.up_busy}, 3'b110);
      @(negedge clk_sys);
      check("inv_after", {bus.up_err, bus.up_done, bus.up_busy}, 3'b100);
      repeat (3) @(negedge clk_sys);
      check("inv_no_busy_rd", (busy_cnt - b0) + (rd_cnt - rd0), 0);
      check("inv_done_once", done_cnt - d0, 1);

      // ---- valid colram start clears err; start while busy; reset at byte 100 ----
      exp_sel = 2'b10; mode = 0;
      rd0 = rd_cnt; d0 = done_cnt; s0 = sel_err;
      bus.up_index = 8'd1; bus.up_start = 1'b1;
      @(negedge clk_sys);
      bus.up_start = 1'b0;
      check("col_start", {bus.up_err, bus.up_busy, bus.mem_sel}, 4'b0110);
      collect(COLRAM_LEN, -1, 50, 100);
      #1;
      check("mid_rst_outs", outs_vec(), 64'd0);
      check("mid_rst_nbytes", n_got, 100);
      check("mid_rst_addr_err", addr_err + data_err, 0);
      check("busy_start_sel", sel_err - s0, 0);
      check("mid_rst_rd", rd_cnt - rd0, 101);
      repeat (3) @(negedge clk_sys);
      check("mid_rst_no_done", done_cnt - d0, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk_sys);

`ifdef UPLOAD_CSUM_EN
      // ---- checksum: all 0x01 -> 0x00 ----
      mode = 1; fill = 8'h01; exp_sel = 2'b10;
      bus.up_index = 8'd1; bus.up_start = 1'b1;
      collect(COLRAM_LEN, -1, -1, -1);
      check("cs1_nbytes", n_got, COLRAM_LEN + 1);
      check("cs1_addr", last_addr, 14'd2048);
      check("cs1_data", last_data, 8'h00);
      @(negedge clk_sys);
      // ---- checksum: byte0=0x06 only -> 0xFA ----
      mode = 2;
      bus.up_index = 8'd1; bus.up_start = 1'b1;
      collect(COLRAM_LEN, -1, -1, -1);
      check("cs2_data_err", data_err, 0);
      check("cs2_data", last_data, 8'hFA);
      @(negedge clk_sys);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
